operand_capture: RTL and testbench
==================================

OPERAND_CAPTURE -- requirements
Module: operand_capture

Interface
REQ-001 Parameter SIZE, default 4: operand width in bits, matching the multiplier operand width.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz): required stable time of the key; legal range 2 and above.
REQ-003 i_clk  input  1  system clock; every flop is clocked on the rising edge.
REQ-004 i_rst  input  1  reset; asynchronous, active-high.
REQ-005 i_sw  input  SIZE  raw slide-switch operand value; asynchronous to i_clk.
REQ-006 i_key_n  input  1  raw push-button; active-low (0 = pressed); asynchronous and bouncing.
REQ-007 o_A  output  SIZE  captured operand A, registered.
REQ-008 o_B  output  SIZE  captured operand B, registered.
REQ-009 o_valid  output  1  high while both operands are captured (READY state), registered.
REQ-010 o_state  output  2  current FSM state encoding, for LED display.

Function
REQ-011 i_sw and i_key_n SHALL each pass through a two-flop synchronizer before any other use.
REQ-012 The debounced key level SHALL take the synchronized level only after that level has differed from the current debounced level for DEBOUNCE_CYCLES consecutive cycles.
REQ-013 Any cycle in which the synchronized level equals the debounced level SHALL clear the stability counter to 0.
REQ-014 A press event SHALL be a one-cycle pulse on the debounced level transition 1->0; the 0->1 transition (release) SHALL generate no event.
REQ-015 A key held indefinitely SHALL generate exactly one press event.
REQ-016 FSM states SHALL be WAIT_A=2'd0, WAIT_B=2'd1 and READY=2'd2; code 2'd3 is illegal and SHALL recover to WAIT_A on the next clock.
REQ-017 WAIT_A + press event: o_A <= synchronized i_sw in the event cycle; next state WAIT_B.
REQ-018 WAIT_B + press event: o_B <= synchronized i_sw in the event cycle; next state READY.
REQ-019 READY + press event: next state WAIT_A; o_A and o_B retain their values.
REQ-020 Without a press event the state, o_A and o_B SHALL hold; switch changes have no effect.
REQ-021 o_valid SHALL be 1 exactly when the registered state is READY; o_state SHALL equal the registered state.
REQ-022 Latency: an output update SHALL appear 1 cycle after the press-event cycle; total latency from the i_key_n fall (clean edge) to the update is 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
REQ-023 Bounce glitches shorter than DEBOUNCE_CYCLES SHALL neither change the debounced level nor create events.
REQ-024 The stability counter SHALL saturate at DEBOUNCE_CYCLES and never wrap; its width SHALL be $clog2(DEBOUNCE_CYCLES+1).

Reset
REQ-025 Asserting i_rst SHALL immediately set: state WAIT_A, o_A=0, o_B=0, o_valid=0, o_state=0, synchronizer flops=released (key 1, switches 0), debounced level=1, counter=0.
REQ-026 Reset asserted during a debounce or after a partial capture SHALL discard all progress; the first press event after release SHALL capture A.
REQ-027 No press event SHALL be generated in the cycle reset deasserts, even with the key held; a key held through reset is detected only after DEBOUNCE_CYCLES of stable low.

Structure
REQ-028 A shared package SHALL hold the state encodings (WAIT_A, WAIT_B, READY), the state width (2) and the default SIZE.
REQ-029 Synchronizer, stability counter and edge detect SHALL form one sub-module, key_debouncer, which outputs the press-event pulse; operand_capture instantiates it and contains the FSM and operand registers.
REQ-030 The outputs SHALL connect directly to the multiplier operand inputs, and o_A/o_B SHALL also feed the seven-segment decoders.

Verification (DEBOUNCE_CYCLES=4, SIZE=4)
REQ-031 Reset, then i_sw=4'h3 and a clean press (held 10 cycles) -> o_A=3 at cycle 2+4+1 after the key fall; o_state=1; o_valid=0.
REQ-032 Then i_sw=4'hB and a second press -> o_B=4'hB, o_state=2, o_valid=1; o_A stays 3.
REQ-033 Bounce pattern on i_key_n of low 2, high 1, low 3, high 2 cycles, then held low -> exactly one event, captured after 4 stable-low cycles.
REQ-034 Key held low 100 cycles, with i_sw toggling every 7 cycles after the capture -> one capture only; o_A keeps the value sampled at the event.
REQ-035 In READY, a press -> o_valid=0 and o_state=0, with o_A/o_B unchanged; the next press overwrites o_A.
REQ-036 i_rst pulsed in WAIT_B in the middle of a debounce -> all outputs 0 and state WAIT_A at once; the next press captures into o_A.

Source files
------------

// File: rtl/operand_capture_pkg.sv
// Shared definitions for the operand capture block: FSM state codes and default widths.
package operand_capture_pkg;

    localparam int STATE_W      = 2;
    localparam int DEFAULT_SIZE = 4;

    typedef enum logic [STATE_W-1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        READY  = 2'd2
    } state_t;

endpackage

// File: rtl/operand_capture_key_debouncer.sv
// Synchronizes the raw key and switches, debounces the key and emits a one-cycle
// pulse on each debounced press (1->0). Release produces no pulse.
module key_debouncer #(
    parameter int SIZE            = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [SIZE-1:0] i_sw,
    input  logic            i_key_n,
    output logic [SIZE-1:0] o_sw_sync,
    output logic            o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [SIZE-1:0] r_sw_s1, r_sw_s2;
    logic            r_key_s1, r_key_s2;
    logic            r_db, r_db_d;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;

    // Saturating so a long disagreement can never wrap back to a small count.
    assign w_cnt_nxt = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CW'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_key_s1 <= 1'b1;
            r_key_s2 <= 1'b1;
            r_db     <= 1'b1;
            r_db_d   <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_sw_s1  <= i_sw;
            r_sw_s2  <= r_sw_s1;
            r_key_s1 <= i_key_n;
            r_key_s2 <= r_key_s1;
            r_db_d   <= r_db;
            if (r_key_s2 == r_db) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_nxt;
                if (w_cnt_nxt == CNT_MAX)
                    r_db <= r_key_s2;
            end
        end
    end

    assign o_sw_sync = r_sw_s2;
    assign o_press   = r_db_d & ~r_db;

endmodule

// File: rtl/operand_capture.sv
// Captures two switch operands on successive debounced key presses; a third press
// returns to WAIT_A while keeping the last operands on the outputs.
module operand_capture
    import operand_capture_pkg::*;
#(
    parameter int SIZE            = DEFAULT_SIZE,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [SIZE-1:0]    i_sw,
    input  logic               i_key_n,
    output logic [SIZE-1:0]    o_A,
    output logic [SIZE-1:0]    o_B,
    output logic               o_valid,
    output logic [STATE_W-1:0] o_state
);

    logic [SIZE-1:0] w_sw;
    logic            w_press;
    state_t          r_state;
    logic [SIZE-1:0] r_A, r_B;
    logic            r_valid;

    key_debouncer #(
        .SIZE           (SIZE),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_sw     (i_sw),
        .i_key_n  (i_key_n),
        .o_sw_sync(w_sw),
        .o_press  (w_press)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= WAIT_A;
            r_A     <= '0;
            r_B     <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                WAIT_A: if (w_press) begin
                    r_A     <= w_sw;
                    r_state <= WAIT_B;
                    r_valid <= 1'b0;
                end
                WAIT_B: if (w_press) begin
                    r_B     <= w_sw;
                    r_state <= READY;
                    r_valid <= 1'b1;
                end
                READY: if (w_press) begin
                    r_state <= WAIT_A;
                    r_valid <= 1'b0;
                end
                // Unused code 2'd3 falls back to the start of the sequence.
                default: begin
                    r_state <= WAIT_A;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_A     = r_A;
    assign o_B     = r_B;
    assign o_valid = r_valid;
    assign o_state = r_state;

endmodule

// File: tb/tb_operand_capture.sv
// Directed test of operand_capture with DEBOUNCE_CYCLES=4, SIZE=4.
module tb_operand_capture;

    localparam int SIZE = 4;
    localparam int DB   = 4;
    localparam int LAT  = 2 + DB + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [SIZE-1:0] sw;
    logic            key_n;
    logic [SIZE-1:0] o_A, o_B;
    logic            o_valid;
    logic [1:0]      o_state;

    int n_vec = 0;
    int n_err = 0;

    operand_capture #(.SIZE(SIZE), .DEBOUNCE_CYCLES(DB)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_sw   (sw),
        .i_key_n(key_n),
        .o_A    (o_A),
        .o_B    (o_B),
        .o_valid(o_valid),
        .o_state(o_state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_key();
        key_n = 1'b1;
        tick(12);
    endtask

    task automatic test_reset();
        rst = 1'b1; sw = '0; key_n = 1'b1;
        tick(3);
        n_vec++; if (o_A !== 4'h0) begin n_err++; $display("FAIL reset_A got %h want 0", o_A); end
        n_vec++; if (o_B !== 4'h0) begin n_err++; $display("FAIL reset_B got %h want 0", o_B); end
        n_vec++; if (o_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", o_state); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", o_valid); end
        rst = 1'b0;
        tick(3);
        n_vec++; if (o_state !== 2'd0) begin n_err++; $display("FAIL post_reset_state got %0d want 0", o_state); end
    endtask

    task automatic test_capture_a();
        sw = 4'h3;
        tick(3);
        key_n = 1'b0;
        tick(LAT - 1);
        n_vec++; if (o_state !== 2'd0) begin n_err++; $display("FAIL a_early_state got %0d want 0", o_state); end
        n_vec++; if (o_A !== 4'h0) begin n_err++; $display("FAIL a_early_A got %h want 0", o_A); end
        tick(1);
        n_vec++; if (o_A !== 4'h3) begin n_err++; $display("FAIL a_capture got %h want 3", o_A); end
        n_vec++; if (o_state !== 2'd1) begin n_err++; $display("FAIL a_state got %0d want 1", o_state); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL a_valid got %b want 0", o_valid); end
        tick(3);
        release_key();
        n_vec++; if (o_state !== 2'd1) begin n_err++; $display("FAIL a_release_state got %0d want 1", o_state); end
    endtask

    task automatic test_capture_b();
        sw = 4'hB;
        tick(3);
        key_n = 1'b0;
        tick(LAT);
        n_vec++; if (o_B !== 4'hB) begin n_err++; $display("FAIL b_capture got %h want b", o_B); end
        n_vec++; if (o_state !== 2'd2) begin n_err++; $display("FAIL b_state got %0d want 2", o_state); end
        n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL b_valid got %b want 1", o_valid); end
        n_vec++; if (o_A !== 4'h3) begin n_err++; $display("FAIL b_A_kept got %h want 3", o_A); end
        tick(3);
        release_key();
    endtask

    task automatic test_ready_press();
        sw = 4'h7;
        key_n = 1'b0;
        tick(LAT);
        n_vec++; if (o_state !== 2'd0) begin n_err++; $display("FAIL ready_state got %0d want 0", o_state); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL ready_valid got %b want 0", o_valid); end
        n_vec++; if (o_A !== 4'h3 || o_B !== 4'hB) begin n_err++; $display("FAIL ready_keep got A=%h B=%h want A=3 B=b", o_A, o_B); end
        tick(3);
        release_key();
        sw = 4'h5;
        tick(3);
        key_n = 1'b0;
        tick(LAT);
        n_vec++; if (o_A !== 4'h5) begin n_err++; $display("FAIL rearm_A got %h want 5", o_A); end
        n_vec++; if (o_state !== 2'd1) begin n_err++; $display("FAIL rearm_state got %0d want 1", o_state); end
        tick(3);
        release_key();
    endtask

    task automatic test_bounce();
        sw = 4'h9;
        tick(3);
        key_n = 1'b0; tick(2);
        key_n = 1'b1; tick(1);
        key_n = 1'b0; tick(3);
        key_n = 1'b1; tick(2);
        key_n = 1'b0;
        tick(LAT - 1);
        n_vec++; if (o_state !== 2'd1 || o_B !== 4'hB) begin n_err++; $display("FAIL bounce_early got state=%0d B=%h want state=1 B=b", o_state, o_B); end
        tick(1);
        n_vec++; if (o_B !== 4'h9) begin n_err++; $display("FAIL bounce_capture got %h want 9", o_B); end
        n_vec++; if (o_state !== 2'd2) begin n_err++; $display("FAIL bounce_state got %0d want 2", o_state); end
        tick(5);
        release_key();
        // Leave READY so the next scenario starts from WAIT_A.
        key_n = 1'b0; tick(LAT + 3);
        release_key();
        n_vec++; if (o_state !== 2'd0) begin n_err++; $display("FAIL bounce_wrap got %0d want 0", o_state); end
    endtask

    task automatic test_held();
        sw = 4'h6;
        tick(3);
        key_n = 1'b0;
        tick(LAT);
        n_vec++; if (o_A !== 4'h6) begin n_err++; $display("FAIL held_capture got %h want 6", o_A); end
        for (int i = LAT; i < 100; i++) begin
            if ((i - LAT) % 7 == 6) sw = ~sw;
            tick(1);
        end
        n_vec++; if (o_state !== 2'd1) begin n_err++; $display("FAIL held_state got %0d want 1", o_state); end
        n_vec++; if (o_A !== 4'h6) begin n_err++; $display("FAIL held_A got %h want 6", o_A); end
        n_vec++; if (o_B !== 4'h9) begin n_err++; $display("FAIL held_B got %h want 9", o_B); end
        release_key();
    endtask

    task automatic test_reset_midway();
        sw = 4'hC;
        tick(3);
        key_n = 1'b0;
        tick(3);
        rst = 1'b1;
        #1;
        n_vec++; if (o_A !== 4'h0 || o_B !== 4'h0) begin n_err++; $display("FAIL midrst_ops got A=%h B=%h want 0 0", o_A, o_B); end
        n_vec++; if (o_state !== 2'd0 || o_valid !== 1'b0) begin n_err++; $display("FAIL midrst_state got st=%0d v=%b want 0 0", o_state, o_valid); end
        tick(1);
        rst = 1'b0;
        tick(LAT - 1);
        n_vec++; if (o_state !== 2'd0 || o_A !== 4'h0) begin n_err++; $display("FAIL midrst_early got st=%0d A=%h want 0 0", o_state, o_A); end
        tick(1);
        n_vec++; if (o_A !== 4'hC) begin n_err++; $display("FAIL midrst_capture got %h want c", o_A); end
        n_vec++; if (o_state !== 2'd1 || o_B !== 4'h0) begin n_err++; $display("FAIL midrst_after got st=%0d B=%h want 1 0", o_state, o_B); end
        release_key();
    endtask

    initial begin
        test_reset();
        test_capture_a();
        test_capture_b();
        test_ready_press();
        test_bounce();
        test_held();
        test_reset_midway();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
